cnn_window_gen: RTL and testbench

//  Producer side of the cnn_core feature-map input. Takes a raster-order pixel stream (CI channels
//  per beat) and builds the KY x KX sliding window: KY-1 line buffers plus a KY x KX shift array.

---
 rtl/cnn_window_gen_pkg.sv | 27 ++
 rtl/cnn_line_buf.sv | 20 ++
 rtl/cnn_window_gen.sv | 98 +++++++++
 tb/tb_cnn_window_gen.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cnn_window_gen_pkg.sv
// cnn_window_gen_pkg: window geometry shared with cnn_core, plus the frame size and counter widths.
package cnn_window_gen_pkg;

   localparam int CI     = 4;
   localparam int KX     = 3;
   localparam int KY     = 3;
   localparam int I_F_BW = 8;
   localparam int IMG_W  = 8;
   localparam int IMG_H  = 8;

   localparam int COL_BW = $clog2(IMG_W);
   localparam int ROW_BW = $clog2(IMG_H);
   localparam int PIX_BW = CI * I_F_BW;
   localparam int WIN_BW = PIX_BW * KX * KY;

   localparam logic [COL_BW-1:0] COL_MAX = COL_BW'(IMG_W - 1);
   localparam logic [ROW_BW-1:0] ROW_MAX = ROW_BW'(IMG_H - 1);

   typedef logic [PIX_BW-1:0] pix_t;
   typedef logic [WIN_BW-1:0] win_t;

   // LSB of sample (ci,ky,kx) in the cnn_core in_fmap packing
   function automatic int fmap_lsb(input int ci, input int ky, input int kx);
      return ((ci * KY + ky) * KX + kx) * I_F_BW;
   endfunction

endpackage

// File: rtl/cnn_line_buf.sv
// cnn_line_buf: one-row delay memory; the read at addr_i returns the sample written there one row ago.
module cnn_line_buf
   import cnn_window_gen_pkg::*;
(
   input  logic              clk,
   input  logic              we_i,
   input  logic [COL_BW-1:0] addr_i,
   input  pix_t              wr_data_i,
   output pix_t              rd_data_o
);

   pix_t mem_q [IMG_W];

   assign rd_data_o = mem_q[addr_i];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[addr_i] <= wr_data_i;
   end

endmodule

// File: rtl/cnn_window_gen.sv
// cnn_window_gen: builds KY x KX sliding windows from a raster pixel stream for cnn_core.
// KY-1 chained line buffers supply the older rows of each new column; a shift array holds KX columns.
module cnn_window_gen
   import cnn_window_gen_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              soft_reset_i,
   input  logic              in_valid_i,
   input  logic [PIX_BW-1:0] in_pixel_i,
   output logic              ot_valid_o,
   output logic [WIN_BW-1:0] ot_fmap_o,
   output logic              ot_last_o
);

   logic              beat;
   logic              col_wrap;
   logic [COL_BW-1:0] col_q, col_d;
   logic [ROW_BW-1:0] row_q, row_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   win_t              fmap_q, fmap_d;
   pix_t              lb_rd   [KY-1];
   pix_t              col_pix [KY];
   pix_t              win_q   [KY][KX];
   pix_t              win_d   [KY][KX];

   assign beat = in_valid_i & ~soft_reset_i;

   for (genvar j = 0; j < KY - 1; j++) begin : g_lb
      pix_t wr_data;
      if (j == 0) begin : g_head
         assign wr_data = in_pixel_i;
      end else begin : g_chain
         assign wr_data = lb_rd[j-1];
      end
      cnn_line_buf u_lb (
         .clk       (clk),
         .we_i      (beat),
         .addr_i    (col_q),
         .wr_data_i (wr_data),
         .rd_data_o (lb_rd[j])
      );
   end

   // Row gating and column gating together guarantee every shifted-in column is from the current row
   always_comb begin
      for (int ky = 0; ky < KY - 1; ky++) col_pix[ky] = lb_rd[KY-2-ky];
      col_pix[KY-1] = in_pixel_i;
      for (int ky = 0; ky < KY; ky++) begin
         for (int kx = 0; kx < KX - 1; kx++) win_d[ky][kx] = win_q[ky][kx+1];
         win_d[ky][KX-1] = col_pix[ky];
      end
      fmap_d = '0;
      for (int ci = 0; ci < CI; ci++)
         for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
               fmap_d[fmap_lsb(ci, ky, kx) +: I_F_BW] = win_d[ky][kx][ci*I_F_BW +: I_F_BW];
      col_wrap = col_q == COL_MAX;
      col_d    = col_wrap ? '0 : col_q + COL_BW'(1);
      row_d    = col_wrap ? ((row_q == ROW_MAX) ? '0 : row_q + ROW_BW'(1)) : row_q;
      valid_d  = beat && (row_q >= ROW_BW'(KY - 1)) && (col_q >= COL_BW'(KX - 1));
      last_d   = valid_d && col_wrap && (row_q == ROW_MAX);
   end

   always_ff @(posedge clk) begin
      if (beat) win_q <= win_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         fmap_q  <= '0;
      end else if (soft_reset_i) begin
         col_q   <= '0;
         row_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         fmap_q  <= '0;
      end else begin
         valid_q <= valid_d;
         last_q  <= last_d;
         if (beat) begin
            col_q <= col_d;
            row_q <= row_d;
         end
         if (valid_d) fmap_q <= fmap_d;
      end
   end

   assign ot_valid_o = valid_q;
   assign ot_last_o  = last_q;
   assign ot_fmap_o  = fmap_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// tb_cnn_window_gen: directed ramp frames against a bench-side window model with exact latency checks.
module tb_cnn_window_gen;
   import cnn_window_gen_pkg::*;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              soft_reset_i = 1'b0;
   logic              in_valid_i = 1'b0;
   logic [PIX_BW-1:0] in_pixel_i = '0;
   logic              ot_valid_o;
   logic [WIN_BW-1:0] ot_fmap_o;
   logic              ot_last_o;

   typedef struct {int r; int c; int cyc;} exp_t;

   exp_t              exp_q [$];
   exp_t              mon_e;
   logic [WIN_BW-1:0] held = '0;
   int                n_run = 0;
   int                n_fail = 0;
   int                cyc = 0;
   int                win_cnt = 0;
   int                last_cnt = 0;

   cnn_window_gen dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .soft_reset_i (soft_reset_i),
      .in_valid_i   (in_valid_i),
      .in_pixel_i   (in_pixel_i),
      .ot_valid_o   (ot_valid_o),
      .ot_fmap_o    (ot_fmap_o),
      .ot_last_o    (ot_last_o)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [WIN_BW-1:0] obs, input logic [WIN_BW-1:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] smp(input int ci, input int r, input int c);
      return 8'(64 * ci + 8 * r + c);
   endfunction

   function automatic logic [PIX_BW-1:0] pix(input int r, input int c);
      logic [PIX_BW-1:0] p;
      for (int ci = 0; ci < CI; ci++) p[ci*8 +: 8] = smp(ci, r, c);
      return p;
   endfunction

   function automatic logic [WIN_BW-1:0] model(input int r, input int c);
      logic [WIN_BW-1:0] v;
      for (int ci = 0; ci < CI; ci++)
         for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
               v[((ci * KY + ky) * KX + kx) * 8 +: 8] = smp(ci, r - KY + 1 + ky, c - KX + 1 + kx);
      return v;
   endfunction

   function automatic logic [7:0] el(input logic [WIN_BW-1:0] f, input int ci, input int ky, input int kx);
      return f[((ci * KY + ky) * KX + kx) * 8 +: 8];
   endfunction

   always @(negedge clk) begin
      if (reset_n) begin
         if (ot_valid_o) begin
            if (exp_q.size() == 0) chk("spurious_valid", 1, 0);
            else begin
               mon_e = exp_q.pop_front();
               held  = model(mon_e.r, mon_e.c);
               chk("latency", cyc, mon_e.cyc);
               chk("fmap", ot_fmap_o, held);
               chk("last", ot_last_o, (mon_e.r == IMG_H - 1) && (mon_e.c == IMG_W - 1));
               if (mon_e.r == 2 && mon_e.c == 2) begin
                  chk("w22_c0_k00", el(ot_fmap_o, 0, 0, 0), 0);
                  chk("w22_c0_k11", el(ot_fmap_o, 0, 1, 1), 9);
                  chk("w22_c0_k22", el(ot_fmap_o, 0, 2, 2), 18);
                  chk("w22_c1_k00", el(ot_fmap_o, 1, 0, 0), 64);
               end
               if (mon_e.r == 3 && mon_e.c == 2) chk("w32_c0_k00", el(ot_fmap_o, 0, 0, 0), 8);
               if (mon_e.r == 7 && mon_e.c == 7) begin
                  chk("w77_c0_k22", el(ot_fmap_o, 0, 2, 2), 63);
                  chk("w77_c0_k00", el(ot_fmap_o, 0, 0, 0), 45);
               end
            end
            win_cnt++;
            if (ot_last_o) last_cnt++;
         end else begin
            chk("last_wo_valid", ot_last_o, 0);
            chk("fmap_hold", ot_fmap_o, held);
         end
      end
   end

   task automatic send(input int r, input int c);
      in_valid_i = 1'b1;
      in_pixel_i = pix(r, c);
      if (r >= KY - 1 && c >= KX - 1) exp_q.push_back('{r, c, cyc + 1});
      @(posedge clk);
      #1;
      in_valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_beats(input int n, input bit gaps);
      for (int i = 0; i < n; i++) begin
         send((i / IMG_W) % IMG_H, i % IMG_W);
         if (gaps) idle($urandom_range(0, 3));
      end
   endtask

   task automatic end_frame(input int nw, input int nl, input string tag);
      idle(3);
      chk({tag, "_windows"}, win_cnt, nw);
      chk({tag, "_lasts"}, last_cnt, nl);
      chk({tag, "_pending"}, exp_q.size(), 0);
      win_cnt  = 0;
      last_cnt = 0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, ot_valid_o, 0);
      chk({tag, "_last"}, ot_last_o, 0);
      chk({tag, "_fmap"}, ot_fmap_o, 0);
   endtask

   initial begin
      #2;
      chk_zero("reset");
      #10;
      reset_n = 1'b1;
      idle(1);

      send_beats(IMG_W * IMG_H, 1'b0);
      end_frame(36, 1, "frame");

      send_beats(IMG_W * IMG_H, 1'b1);
      end_frame(36, 1, "gapped");

      send_beats(2 * IMG_W * IMG_H, 1'b0);
      end_frame(72, 2, "two_frames");

      send_beats(4 * IMG_W + 5, 1'b0);
      soft_reset_i = 1'b1;
      in_valid_i   = 1'b1;
      in_pixel_i   = pix(4, 5);
      @(posedge clk);
      #1;
      soft_reset_i = 1'b0;
      in_valid_i   = 1'b0;
      held         = '0;
      chk_zero("soft_reset");
      send_beats(IMG_W * IMG_H, 1'b0);
      end_frame(51, 1, "after_soft");

      send_beats(4 * IMG_W + 5, 1'b0);
      #6;
      chk("pre_async_valid", ot_valid_o, 1);
      reset_n = 1'b0;
      held    = '0;
      #1;
      chk_zero("async_reset");
      #3;
      reset_n = 1'b1;
      send_beats(IMG_W * IMG_H, 1'b0);
      end_frame(51, 1, "after_async");

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
